// File: rtl/ysyx_22041412_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22041412_mem_arbiter
// Brief    : Two-requester (fetch / data) arbiter onto a single SRAM port with
//            starvation guard for fetch and a completion timeout abort.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_22041412_mem_arbiter #(
  parameter int MAX_STARVE = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [63:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        mem_req,
  input  logic        mem_wen,
  input  logic [2:0]  mem_func3,
  input  logic [63:0] mem_addr,
  input  logic [63:0] mem_wdata,
  output logic [63:0] mem_rdata,
  output logic        mem_ready,
  output logic        ram_en,
  output logic        ram_wen,
  output logic [2:0]  ram_func3,
  output logic [63:0] ram_addr,
  output logic [63:0] ram_wdata,
  input  logic [63:0] ram_rdata,
  input  logic        ram_readyo,
  output logic [1:0]  grant,
  output logic        err
);

  localparam int c_STARVE_W = $clog2(MAX_STARVE + 1);
  localparam int c_WAIT_W   = $clog2(TIMEOUT + 1);
  localparam logic [c_STARVE_W-1:0] c_MAX_STARVE = c_STARVE_W'(MAX_STARVE);
  localparam logic [c_WAIT_W-1:0]   c_TIMEOUT    = c_WAIT_W'(TIMEOUT);
  localparam logic [2:0]            c_FETCH_FUNC3 = 3'b110;

  // State encoding doubles as the grant output.
  typedef enum logic [1:0] {
    S_IDLE     = 2'b00,
    S_BUSY_IF  = 2'b01,
    S_BUSY_MEM = 2'b10
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [c_STARVE_W-1:0] r_starve_cnt;
  logic [c_WAIT_W-1:0]   r_wait_cnt;
  logic                  w_grant_if;
  logic                  w_grant_mem;
  logic                  w_done;
  logic                  w_timeout;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_grant_if   = 1'b0;
    w_grant_mem  = 1'b0;
    w_done       = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Data wins unless fetch has been starved MAX_STARVE times in a row.
        if (mem_req && (!if_req || (r_starve_cnt < c_MAX_STARVE))) begin
          w_grant_mem  = 1'b1;
          w_next_state = S_BUSY_MEM;
        end else if (if_req) begin
          w_grant_if   = 1'b1;
          w_next_state = S_BUSY_IF;
        end
      end
      S_BUSY_IF, S_BUSY_MEM: begin
        // Completion takes precedence over a coincident timeout.
        if (ram_readyo) begin
          w_done       = 1'b1;
          w_next_state = S_IDLE;
        end else if (r_wait_cnt == c_TIMEOUT) begin
          w_timeout    = 1'b1;
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  assign grant = r_state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ram_en       <= 1'b0;
      ram_wen      <= 1'b0;
      ram_func3    <= 3'b000;
      ram_addr     <= 64'd0;
      ram_wdata    <= 64'd0;
      if_rdata     <= 32'd0;
      mem_rdata    <= 64'd0;
      if_ready     <= 1'b0;
      mem_ready    <= 1'b0;
      err          <= 1'b0;
      r_starve_cnt <= '0;
      r_wait_cnt   <= '0;
    end else begin
      if_ready  <= 1'b0;
      mem_ready <= 1'b0;
      err       <= 1'b0;

      if (w_grant_mem) begin
        ram_en    <= 1'b1;
        ram_wen   <= mem_wen;
        ram_func3 <= mem_func3;
        ram_addr  <= mem_addr;
        ram_wdata <= mem_wdata;
      end else if (w_grant_if) begin
        ram_en    <= 1'b1;
        ram_wen   <= 1'b0;
        ram_func3 <= c_FETCH_FUNC3;
        ram_addr  <= if_addr;
        ram_wdata <= 64'd0;
      end else if (w_done || w_timeout) begin
        ram_en <= 1'b0;
      end

      if (w_done) begin
        if (r_state == S_BUSY_IF) begin
          if_ready <= 1'b1;
          if_rdata <= ram_addr[2] ? ram_rdata[63:32] : ram_rdata[31:0];
        end else begin
          mem_ready <= 1'b1;
          if (!ram_wen) begin
            mem_rdata <= ram_rdata;
          end
        end
      end

      if (w_timeout) begin
        err <= 1'b1;
      end

      if (w_grant_if) begin
        r_starve_cnt <= '0;
      end else if (w_grant_mem && if_req && (r_starve_cnt < c_MAX_STARVE)) begin
        r_starve_cnt <= r_starve_cnt + 1'b1;
      end

      if (w_grant_if || w_grant_mem) begin
        r_wait_cnt <= '0;
      end else if ((r_state != S_IDLE) && !ram_readyo && !w_timeout) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
